// File: rtl/hazard_tracker_pkg.sv
// -----------------------------------------------------------------------------
// hazard_tracker_pkg
// Shared pipeline definitions for the hazard/forwarding unit:
//   - forwarding select encodings for the D-stage and E-stage muxes
//   - Tuse/Tnew limits and small address/Tnew types
//   - helper functions for Tnew clipping/decrement, stall and forward decisions
// -----------------------------------------------------------------------------
package hazard_tracker_pkg;

    typedef logic [4:0] reg_addr_t;
    typedef logic [1:0] tnew_t;

    // D-stage operand source: register file, E-stage result, M-stage result
    localparam logic [1:0] FWD_D_RF  = 2'd0;
    localparam logic [1:0] FWD_D_E   = 2'd1;
    localparam logic [1:0] FWD_D_M   = 2'd2;

    // E-stage operand source: D/E pipeline register, M-stage result, W-stage result
    localparam logic [1:0] FWD_E_REG = 2'd0;
    localparam logic [1:0] FWD_E_M   = 2'd1;
    localparam logic [1:0] FWD_E_W   = 2'd2;

    localparam logic [2:0] TUSE_NONE = 3'd4;
    localparam tnew_t      TNEW_MAX  = 2'd2;

    // Decoder Tnew is 3 bits wide; anything beyond the pipeline depth is held at the max.
    function automatic tnew_t tnew_clip(input logic [2:0] t);
        if (t > {1'b0, TNEW_MAX}) begin
            return TNEW_MAX;
        end else begin
            return t[1:0];
        end
    endfunction

    // One stage older means one cycle closer to the result; saturates at zero.
    function automatic tnew_t tnew_dec(input tnew_t t);
        if (t == 2'd0) begin
            return 2'd0;
        end else begin
            return t - 2'd1;
        end
    endfunction

    // A reader must wait if a tracked writer of the same register will not have its
    // result ready by the time the reader needs it. $0 is never a dependency.
    function automatic logic need_stall(input reg_addr_t a, input logic [2:0] tuse,
                                        input reg_addr_t a3, input tnew_t tnew);
        return (a != 5'd0) && (a == a3) && (tuse < {1'b0, tnew});
    endfunction

    // D-stage select: the younger writer in E takes precedence over M.
    function automatic logic [1:0] fwd_d_sel(input reg_addr_t a,
                                             input reg_addr_t a3e, input tnew_t tnewe,
                                             input reg_addr_t a3m, input tnew_t tnewm);
        if ((a != 5'd0) && (a == a3e) && (tnewe == 2'd0)) begin
            return FWD_D_E;
        end else if ((a != 5'd0) && (a == a3m) && (tnewm == 2'd0)) begin
            return FWD_D_M;
        end else begin
            return FWD_D_RF;
        end
    endfunction

    // E-stage select: M wins over W; a W writer always has its result ready.
    function automatic logic [1:0] fwd_e_sel(input reg_addr_t a,
                                             input reg_addr_t a3m, input tnew_t tnewm,
                                             input reg_addr_t a3w);
        if ((a != 5'd0) && (a == a3m) && (tnewm == 2'd0)) begin
            return FWD_E_M;
        end else if ((a != 5'd0) && (a == a3w)) begin
            return FWD_E_W;
        end else begin
            return FWD_E_REG;
        end
    endfunction

endpackage

// File: rtl/hazard_stage_reg.sv
// -----------------------------------------------------------------------------
// hazard_stage_reg
// Holds the destination register and remaining Tnew of the writer in one
// pipeline stage.
//   clk      in  : pipeline clock
//   rst_n    in  : asynchronous active-low reset
//   bubble_i in  : capture an empty slot (no writer) instead of the inputs
//   a3_i     in  : destination register arriving from the previous stage
//   tnew_i   in  : remaining Tnew arriving from the previous stage
//   a3_o     out : destination register held in this stage
//   tnew_o   out : remaining Tnew held in this stage
// DECREMENT selects whether Tnew ages by one cycle on entry to this stage.
// -----------------------------------------------------------------------------
module hazard_stage_reg
    import hazard_tracker_pkg::*;
#(
    parameter bit DECREMENT = 1'b0
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      bubble_i,
    input  reg_addr_t a3_i,
    input  tnew_t     tnew_i,
    output reg_addr_t a3_o,
    output tnew_t     tnew_o
);

    reg_addr_t a3_d, a3_q;
    tnew_t     tnew_d, tnew_q;

    // Next-state: bubble clears the slot, otherwise take (and optionally age) the input.
    always_comb begin
        a3_d   = 5'd0;
        tnew_d = 2'd0;
        if (bubble_i) begin
            a3_d   = 5'd0;
            tnew_d = 2'd0;
        end else begin
            a3_d   = a3_i;
            tnew_d = DECREMENT ? tnew_dec(tnew_i) : tnew_i;
        end
    end

    // Stage register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a3_q   <= 5'd0;
            tnew_q <= 2'd0;
        end else begin
            a3_q   <= a3_d;
            tnew_q <= tnew_d;
        end
    end

    assign a3_o   = a3_q;
    assign tnew_o = tnew_q;

endmodule

// File: rtl/hazard_tracker.sv
// -----------------------------------------------------------------------------
// hazard_tracker
// Hazard detection and forwarding control for a 5-stage pipeline, driven by the
// D-stage decoder's Tuse/Tnew codes. Tracks in-flight writers in E, M and W.
//   clk       in  : pipeline clock
//   reset     in  : asynchronous active-low reset
//   A1D/A2D   in  : rs/rt of the instruction in D
//   TuseRs/Rt in  : cycles until rs/rt is needed (4 = unused)
//   A3D/RFWED in  : destination and write enable of the instruction in D
//   TnewE     in  : cycles after entering E until its result exists
//   cnt_clr   in  : synchronous clear of the stall counter
//   stall     out : freeze PC and F/D, bubble into E (combinational)
//   FwdRsD/RtD out: D-stage operand selects (0 RF, 1 E, 2 M)
//   FwdRsE/RtE out: E-stage operand selects (0 D/E reg, 1 M, 2 W)
//   stall_cnt out : saturating count of stall cycles
// -----------------------------------------------------------------------------
module hazard_tracker
    import hazard_tracker_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       A1D,
    input  logic [4:0]       A2D,
    input  logic [2:0]       TuseRs,
    input  logic [2:0]       TuseRt,
    input  logic [4:0]       A3D,
    input  logic             RFWED,
    input  logic [2:0]       TnewE,
    input  logic             cnt_clr,
    output logic             stall,
    output logic [1:0]       FwdRsD,
    output logic [1:0]       FwdRtD,
    output logic [1:0]       FwdRsE,
    output logic [1:0]       FwdRtE,
    output logic [CNT_W-1:0] stall_cnt
);

    reg_addr_t  a3e_s, a3m_s, a3d_wr_s;
    tnew_t      tnewe_s, tnewm_s;
    reg_addr_t  a1e_d, a1e_q, a2e_d, a2e_q;
    reg_addr_t  a3w_d, a3w_q;
    logic       stall_rs_s, stall_rt_s, stall_s;
    logic [CNT_W-1:0] cnt_d, cnt_q;

    // Non-writing instructions enter E as a writer of $0, which matches nothing.
    assign a3d_wr_s = RFWED ? A3D : 5'd0;

    hazard_stage_reg #(.DECREMENT(1'b0)) u_stage_e (
        .clk      (clk),
        .rst_n    (reset),
        .bubble_i (stall_s),
        .a3_i     (a3d_wr_s),
        .tnew_i   (tnew_clip(TnewE)),
        .a3_o     (a3e_s),
        .tnew_o   (tnewe_s)
    );

    hazard_stage_reg #(.DECREMENT(1'b1)) u_stage_m (
        .clk      (clk),
        .rst_n    (reset),
        .bubble_i (1'b0),
        .a3_i     (a3e_s),
        .tnew_i   (tnewe_s),
        .a3_o     (a3m_s),
        .tnew_o   (tnewm_s)
    );

    // Hazard detection against the E and M writers; W results reach D via the RF bypass.
    always_comb begin
        stall_rs_s = need_stall(A1D, TuseRs, a3e_s, tnewe_s) |
                     need_stall(A1D, TuseRs, a3m_s, tnewm_s);
        stall_rt_s = need_stall(A2D, TuseRt, a3e_s, tnewe_s) |
                     need_stall(A2D, TuseRt, a3m_s, tnewm_s);
        stall_s    = stall_rs_s | stall_rt_s;
    end

    // Next-state for E source addresses and W destination; a stall inserts a bubble.
    always_comb begin
        a1e_d = 5'd0;
        a2e_d = 5'd0;
        a3w_d = a3m_s;
        if (stall_s) begin
            a1e_d = 5'd0;
            a2e_d = 5'd0;
        end else begin
            a1e_d = A1D;
            a2e_d = A2D;
        end
    end

    // E source addresses and W destination registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a1e_q <= 5'd0;
            a2e_q <= 5'd0;
            a3w_q <= 5'd0;
        end else begin
            a1e_q <= a1e_d;
            a2e_q <= a2e_d;
            a3w_q <= a3w_d;
        end
    end

    // Stall counter next-state: clear wins, otherwise saturating increment.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (stall_s && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign stall     = stall_s;
    assign FwdRsD    = fwd_d_sel(A1D, a3e_s, tnewe_s, a3m_s, tnewm_s);
    assign FwdRtD    = fwd_d_sel(A2D, a3e_s, tnewe_s, a3m_s, tnewm_s);
    assign FwdRsE    = fwd_e_sel(a1e_q, a3m_s, tnewm_s, a3w_q);
    assign FwdRtE    = fwd_e_sel(a2e_q, a3m_s, tnewm_s, a3w_q);
    assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_hazard_tracker.sv
// -----------------------------------------------------------------------------
// tb_hazard_tracker
// Directed, table-driven bench for hazard_tracker. Each row is one D-stage cycle:
// inputs are driven after the falling edge and outputs compared before the next
// rising edge. Hand sequences cover async reset mid-stall, counter clear and
// counter saturation (counter narrowed to 3 bits so saturation is reachable).
// -----------------------------------------------------------------------------
module tb_hazard_tracker;

    localparam int CW = 3;

    logic          clk;
    logic          reset;
    logic [4:0]    A1D, A2D, A3D;
    logic [2:0]    TuseRs, TuseRt, TnewE;
    logic          RFWED, cnt_clr;
    logic          stall;
    logic [1:0]    FwdRsD, FwdRtD, FwdRsE, FwdRtE;
    logic [CW-1:0] stall_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [4:0] a1, a2;
        logic [2:0] tus, tut;
        logic [4:0] a3;
        logic       we;
        logic [2:0] tn;
        logic       clr;
        logic       st;
        logic [1:0] frd, ftd, fre, fte;
        logic [2:0] cnt;
    } vec_t;

    vec_t tbl[$];

    hazard_tracker #(.CNT_W(CW)) dut (
        .clk       (clk),
        .reset     (reset),
        .A1D       (A1D),
        .A2D       (A2D),
        .TuseRs    (TuseRs),
        .TuseRt    (TuseRt),
        .A3D       (A3D),
        .RFWED     (RFWED),
        .TnewE     (TnewE),
        .cnt_clr   (cnt_clr),
        .stall     (stall),
        .FwdRsD    (FwdRsD),
        .FwdRtD    (FwdRtD),
        .FwdRsE    (FwdRsE),
        .FwdRtE    (FwdRtE),
        .stall_cnt (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input int a1, input int a2, input int tus, input int tut,
                                input int a3, input int we, input int tn, input int clr,
                                input int st, input int frd, input int ftd,
                                input int fre, input int fte, input int cnt);
        vec_t v;
        v.a1 = a1[4:0]; v.a2 = a2[4:0]; v.tus = tus[2:0]; v.tut = tut[2:0];
        v.a3 = a3[4:0]; v.we = we[0];   v.tn = tn[2:0];   v.clr = clr[0];
        v.st = st[0];   v.frd = frd[1:0]; v.ftd = ftd[1:0];
        v.fre = fre[1:0]; v.fte = fte[1:0]; v.cnt = cnt[2:0];
        return v;
    endfunction

    function automatic vec_t nop(input int cnt);
        return mk(0, 0, 4, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, cnt);
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        A1D = v.a1; A2D = v.a2; TuseRs = v.tus; TuseRt = v.tut;
        A3D = v.a3; RFWED = v.we; TnewE = v.tn; cnt_clr = v.clr;
    endtask

    task automatic check_outs(input string tag, input vec_t v);
        chk({tag, ".stall"},  {15'd0, stall},           {15'd0, v.st});
        chk({tag, ".FwdRsD"}, {14'd0, FwdRsD},          {14'd0, v.frd});
        chk({tag, ".FwdRtD"}, {14'd0, FwdRtD},          {14'd0, v.ftd});
        chk({tag, ".FwdRsE"}, {14'd0, FwdRsE},          {14'd0, v.fre});
        chk({tag, ".FwdRtE"}, {14'd0, FwdRtE},          {14'd0, v.fte});
        chk({tag, ".cnt"},    {{(16-CW){1'b0}}, stall_cnt}, {13'd0, v.cnt});
    endtask

    task automatic run_row(input string tag, input vec_t v);
        @(negedge clk);
        drive(v);
        #2;
        check_outs(tag, v);
    endtask

    initial begin
        vec_t lw, beq, beq_c;
        int   cm;

        // rows: a1 a2 tus tut a3 we tn clr | st frd ftd fre fte cnt
        // lw $1 ; addu $2,$1,$3 : one stall, then W->E forward
        tbl.push_back(mk(0, 0, 4, 4, 1, 1, 2, 0,  0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 3, 1, 1, 2, 1, 1, 0,  1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 3, 1, 1, 2, 1, 1, 0,  0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 4, 4, 0, 0, 0, 0,  0, 0, 0, 2, 0, 1));
        tbl.push_back(nop(1));
        tbl.push_back(nop(1));
        // lw $1 ; beq $1,$1 : two stalls, then RF bypass (no forward)
        tbl.push_back(mk(0, 0, 4, 4, 1, 1, 2, 0,  0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 1));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 2));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 3));
        tbl.push_back(nop(3));
        // addu $1 ; beq $1 : one stall, then M->D forward
        tbl.push_back(mk(0, 0, 4, 4, 1, 1, 1, 0,  0, 0, 0, 0, 0, 3));
        tbl.push_back(mk(1, 0, 0, 4, 0, 0, 0, 0,  1, 0, 0, 0, 0, 3));
        tbl.push_back(mk(1, 0, 0, 4, 0, 0, 0, 0,  0, 2, 0, 0, 0, 4));
        tbl.push_back(mk(0, 0, 4, 4, 0, 0, 0, 0,  0, 0, 0, 2, 0, 4));
        tbl.push_back(nop(4));
        // addu $1 ; addu $4,$1,$1 : no stall, M->E forward on both operands
        tbl.push_back(mk(0, 0, 4, 4, 1, 1, 1, 0,  0, 0, 0, 0, 0, 4));
        tbl.push_back(mk(1, 1, 1, 1, 4, 1, 1, 0,  0, 0, 0, 0, 0, 4));
        tbl.push_back(mk(0, 0, 4, 4, 0, 0, 0, 0,  0, 0, 0, 1, 1, 4));
        tbl.push_back(nop(4));
        tbl.push_back(nop(4));
        // writer of $0 then reader of $0 : never stalls or forwards
        tbl.push_back(mk(0, 0, 4, 4, 0, 1, 2, 0,  0, 0, 0, 0, 0, 4));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0,  0, 0, 0, 0, 0, 4));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0,  0, 0, 0, 0, 0, 4));
        // Tnew=0 writer : E->D forward on rt, then M->E forward on rt
        tbl.push_back(mk(0, 0, 4, 4, 5, 1, 0, 0,  0, 0, 0, 0, 0, 4));
        tbl.push_back(mk(0, 5, 4, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0, 4));
        // TnewE=7 is held as 2 : reader with Tuse=0 stalls exactly twice
        tbl.push_back(mk(0, 0, 4, 4, 6, 1, 7, 0,  0, 0, 0, 0, 1, 4));
        tbl.push_back(mk(6, 0, 0, 4, 0, 0, 0, 0,  1, 0, 0, 0, 0, 4));
        tbl.push_back(mk(6, 0, 0, 4, 0, 0, 0, 0,  1, 0, 0, 0, 0, 5));
        tbl.push_back(mk(6, 0, 0, 4, 0, 0, 0, 0,  0, 0, 0, 0, 0, 6));
        tbl.push_back(nop(6));

        // reset state
        reset = 1'b0;
        drive(nop(0));
        #3;
        check_outs("reset", nop(0));
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        foreach (tbl[i]) begin
            run_row($sformatf("row%0d", i), tbl[i]);
        end

        // async reset during the second cycle of a two-cycle stall
        lw  = mk(0, 0, 4, 4, 1, 1, 2, 0,  0, 0, 0, 0, 0, 6);
        beq = mk(1, 1, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 6);
        run_row("rst_lw", lw);
        run_row("rst_beq1", beq);
        @(negedge clk);
        #1;
        chk("rst_pre.stall", {15'd0, stall}, 16'd1);
        chk("rst_pre.cnt", {{(16-CW){1'b0}}, stall_cnt}, 16'd7);
        reset = 1'b0;
        #1;
        chk("rst_now.stall", {15'd0, stall}, 16'd0);
        chk("rst_now.cnt", {{(16-CW){1'b0}}, stall_cnt}, 16'd0);
        chk("rst_now.FwdRsE", {14'd0, FwdRsE}, 16'd0);
        @(negedge clk);
        reset = 1'b1;
        #2;
        chk("rst_rel.stall", {15'd0, stall}, 16'd0);
        run_row("rst_nop", nop(0));

        // cnt_clr during a stall beats the increment
        run_row("clr_lw", mk(0, 0, 4, 4, 1, 1, 2, 0,  0, 0, 0, 0, 0, 0));
        run_row("clr_beq1", mk(1, 1, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0));
        run_row("clr_beq2", mk(1, 1, 0, 0, 0, 0, 0, 1,  1, 0, 0, 0, 0, 1));
        run_row("clr_beq3", mk(1, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0));

        // saturation: five lw/beq pairs give ten stalls into a 3-bit counter
        cm = 0;
        for (int k = 0; k < 5; k++) begin
            lw    = mk(0, 0, 4, 4, 1, 1, 2, 0,  0, 0, 0, 0, 0, cm);
            run_row($sformatf("sat%0d_lw", k), lw);
            beq   = mk(1, 1, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, cm);
            run_row($sformatf("sat%0d_b1", k), beq);
            cm    = (cm == 7) ? 7 : cm + 1;
            beq   = mk(1, 1, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, cm);
            run_row($sformatf("sat%0d_b2", k), beq);
            cm    = (cm == 7) ? 7 : cm + 1;
            beq_c = mk(1, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, cm);
            run_row($sformatf("sat%0d_b3", k), beq_c);
        end
        run_row("sat_final", nop(7));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_tracker.md
# hazard_tracker

Hazard and forwarding unit fed directly by the D-stage control decoder. It consumes the D-stage register addresses, Tuse/Tnew codes, and write target. It tracks each in-flight writer's destination and remaining Tnew through the E, M and W stages. From that state it produces the pipeline stall, the D- and E-stage forwarding selects, and a saturating stall-cycle counter for performance measurement.

## Interface
- `CNT_W`, default 16: stall counter width.
- `clk` in 1: pipeline clock, all state on rising edge.
- `reset` in 1: asynchronous, active-low; clears all state.
- `A1D` in 5: rs field of instruction in D.
- `A2D` in 5: rt field of instruction in D.
- `TuseRs` in 3: cycles until rs is needed; 4 = unused.
- `TuseRt` in 3: cycles until rt is needed; 4 = unused.
- `A3D` in 5: destination register of instruction in D.
- `RFWED` in 1: instruction in D writes the register file.
- `TnewE` in 3: cycles after entering E until the result exists (0..2).
- `cnt_clr` in 1: synchronous clear of the stall counter.
- `stall` out 1: freeze PC and F/D register; insert bubble into E.
- `FwdRsD` out 2: D-stage rs source; 0 = RF, 1 = E, 2 = M.
- `FwdRtD` out 2: D-stage rt source; same encoding as `FwdRsD`.
- `FwdRsE` out 2: E-stage rs source; 0 = D/E reg, 1 = M, 2 = W.
- `FwdRtE` out 2: E-stage rt source; same encoding as `FwdRsE`.
- `stall_cnt` out CNT_W: number of stall cycles since reset or clear.

## Operation
- **Tracked state:**
  - Stage E: A3E, TnewE_r, A1E, A2E.
  - Stage M: A3M, TnewM.
  - Stage W: A3W.
  - Tnew is held in 2 bits. An input TnewE > 2 is captured as 2.
- **D→E capture, each edge:**
  - If `stall` = 0: A1E ← A1D, A2E ← A2D, TnewE_r ← TnewE, and A3E ← (RFWED ? A3D : 0).
  - If `stall` = 1: the bubble A3E = 0, TnewE_r = 0, A1E = 0, A2E = 0 is captured.
- **E→M:** A3M ← A3E; TnewM ← (TnewE_r = 0) ? 0 : TnewE_r − 1.
- **M→W:** A3W ← A3M. TnewW is implicitly 0.
- **$0 rule:** any address 0 never matches, so it never stalls and never forwards.
- **Stall:** `stall` = stall_rs | stall_rt.
  - stall_rs = A1D≠0 ∧ ((A1D=A3E ∧ TuseRs<TnewE_r) ∨ (A1D=A3M ∧ TuseRs<TnewM)).
  - stall_rt is identical, using A2D and TuseRt.
  - Tuse = 4 never stalls.
- **D forwarding, rs:**
  - 1 if A1D≠0 ∧ A1D=A3E ∧ TnewE_r=0.
  - Else 2 if A1D≠0 ∧ A1D=A3M ∧ TnewM=0.
  - Else 0.
  - The younger writer (E) wins. rt is identical with A2D.
  - The W→D path is covered by RF internal bypass, not this block.
- **E forwarding, rs:**
  - 1 if A1E≠0 ∧ A1E=A3M ∧ TnewM=0.
  - Else 2 if A1E≠0 ∧ A1E=A3W.
  - Else 0. rt is identical with A2E.
- **Counter:**
  - `cnt_clr` = 1 → 0, taking priority over increment.
  - Else `stall` = 1 → +1, saturating at all-ones (no wrap).

## Timing
- Reset (async, `reset` = 0): all state 0; `stall` = 0, all Fwd = 0, `stall_cnt` = 0, immediately without a clock edge. Reset asserted mid-stall drops `stall` in the same cycle.
- `stall` and Fwd* are combinational from current D inputs plus registered state, valid within the same cycle. No registered output latency apart from `stall_cnt`.
- A producer with Tnew = t in E stalls a dependent D instruction for max(0, t − Tuse) cycles.
- `stall_cnt` reflects stall cycles through the previous edge.
- A stall and a D-forward can coexist on different operands. The D-stage consumer must ignore Fwd while `stall` = 1.

## Structure
- Shared pipeline package holds:
  - Fwd encodings: FWD_RF/FWD_E/FWD_M and FWD_REG/FWD_M/FWD_W.
  - TUSE_NONE = 4.
  - TNEW_MAX = 2.
- One sub-module, `hazard_stage_reg`: holds A3/Tnew for one stage with bubble and decrement-saturate logic, instantiated for E and M.

## Test plan
- `lw $1` (TnewE = 2) then `addu $2,$1,$3` (TuseRs = 1) → `stall` = 1 for exactly 1 cycle, then `FwdRsE` = 2 (from W) in the addu's E cycle; `stall_cnt` = 1.
- `lw $1` then `beq $1,$1` (TuseRs = TuseRt = 0) → 2 stall cycles, then `FwdRsD` = `FwdRtD` = 0 (RF bypass); `stall_cnt` = 2.
- `addu $1` (TnewE = 1) then `beq $1` → 1 stall cycle, then `FwdRsD` = 2 (M).
- `addu $1` then `addu $4,$1,$1` → no stall; next cycle `FwdRsE` = `FwdRtE` = 1 (M).
- Writer to $0 (A3D = 0, RFWED = 1) then reader of $0 → `stall` = 0 and all Fwd = 0 throughout.
- 3-cycle stall sequence with `reset` pulled low in cycle 2 → `stall` and `stall_cnt` drop to 0 immediately. `cnt_clr` pulsed during a stall → counter reads 0 the following cycle.
